// File: rtl/prbs31_pkg.sv
// rtl/prbs31_pkg.sv - PRBS31 checker shared constants, state type and parameter defaults
package prbs31_pkg;

   // Polynomial x^31 + x^28 + 1: the prediction taps the two oldest relevant history bits
   localparam int SR_W  = 31;
   localparam int TAP_A = 30;
   localparam int TAP_B = 27;

   localparam int LOCK_GOOD_DEF = 64;
   localparam int LOSS_WIN_DEF  = 256;
   localparam int LOSS_THR_DEF  = 8;

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/prbs31_checker_if.sv
// rtl/prbs31_checker_if.sv - serial data in / lock and error status out bundle for the PRBS31 checker
interface prbs31_checker_if;
   logic        din;
   logic        din_valid;
   logic        clr_cnt;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_cnt;
   logic [31:0] bit_cnt;

   modport master (
      output din, din_valid, clr_cnt,
      input  locked, err_pulse, err_cnt, bit_cnt
   );

   modport slave (
      input  din, din_valid, clr_cnt,
      output locked, err_pulse, err_cnt, bit_cnt
   );
endinterface

// File: rtl/prbs31_pred.sv
// rtl/prbs31_pred.sv - 31-bit PRBS history register and next-bit predictor
module prbs31_pred
   import prbs31_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic shift_en,
   input  logic sel_exp,
   input  logic din,
   output logic exp_bit,
   output logic next_nz
);

   logic [SR_W-1:0] sr_q, sr_d;
   logic            shift_bit;

   assign exp_bit   = sr_q[TAP_A] ^ sr_q[TAP_B];
   // When locked, the predicted bit is fed back so a corrupted input cannot poison the history
   assign shift_bit = sel_exp ? exp_bit : din;
   assign next_nz   = |{sr_q[SR_W-2:0], shift_bit};

   // Newest bit enters at sr[0]; history only moves on valid cycles
   always_comb begin
      sr_d = sr_q;
      if (shift_en) begin
         sr_d = {sr_q[SR_W-2:0], shift_bit};
      end
   end

   // History register with synchronous active-high clear
   always_ff @(posedge clk) begin
      if (rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

endmodule

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - PRBS31 lock/error checker; PRBS31_CHK_BITCNT_EN adds the checked-bit counter
module prbs31_checker
   import prbs31_pkg::*;
#(
   parameter int LOCK_GOOD = LOCK_GOOD_DEF,
   parameter int LOSS_WIN  = LOSS_WIN_DEF,
   parameter int LOSS_THR  = LOSS_THR_DEF
) (
   input logic             clk,
   input logic             rst_n,
   prbs31_checker_if.slave bus
);

   localparam int GW = $clog2(LOCK_GOOD + 1);
   localparam int WW = $clog2(LOSS_WIN + 1);
   localparam int EW = $clog2(LOSS_THR + 1);

   localparam logic [4:0]    SEED_LAST = 5'(SR_W - 1);
   localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_GOOD - 1);
   localparam logic [WW-1:0] WIN_LAST  = WW'(LOSS_WIN - 1);
   localparam logic [EW-1:0] ERR_LAST  = EW'(LOSS_THR - 1);

   state_t          state_q, state_d;
   logic [4:0]      seed_cnt_q, seed_cnt_d;
   logic [GW-1:0]   good_cnt_q, good_cnt_d;
   logic [WW-1:0]   win_cnt_q, win_cnt_d;
   logic [EW-1:0]   err_win_q, err_win_d;
   logic            locked_q, locked_d;
   logic            err_pulse_q, err_pulse_d;
   logic [15:0]     err_cnt_q, err_cnt_d;
   logic            exp_bit, next_nz, mismatch;

   prbs31_pred u_pred (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (bus.din_valid),
      .sel_exp  (state_q == LOCKED),
      .din      (bus.din),
      .exp_bit  (exp_bit),
      .next_nz  (next_nz)
   );

   assign mismatch = bus.din ^ exp_bit;

   // Seed/verify/track sequencing, loss-of-lock window and error counting; invalid cycles hold everything
   always_comb begin
      state_d     = state_q;
      seed_cnt_d  = seed_cnt_q;
      good_cnt_d  = good_cnt_q;
      win_cnt_d   = win_cnt_q;
      err_win_d   = err_win_q;
      err_pulse_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      if (bus.din_valid) begin
         case (state_q)
            SEED: begin
               if (seed_cnt_q == SEED_LAST) begin
                  seed_cnt_d = '0;
                  // An all-zero history is the LFSR lock-up state and can never verify
                  if (next_nz) begin
                     state_d    = VERIFY;
                     good_cnt_d = '0;
                  end
               end else begin
                  seed_cnt_d = seed_cnt_q + 5'd1;
               end
            end
            VERIFY: begin
               if (mismatch) begin
                  state_d    = SEED;
                  seed_cnt_d = '0;
               end else if (good_cnt_q == GOOD_LAST) begin
                  state_d   = LOCKED;
                  win_cnt_d = '0;
                  err_win_d = '0;
               end else begin
                  good_cnt_d = good_cnt_q + 1'b1;
               end
            end
            LOCKED: begin
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  if (err_cnt_q != 16'hFFFF) begin
                     err_cnt_d = err_cnt_q + 16'd1;
                  end
               end
               if (mismatch && (err_win_q == ERR_LAST)) begin
                  state_d    = SEED;
                  seed_cnt_d = '0;
                  win_cnt_d  = '0;
                  err_win_d  = '0;
               end else if (win_cnt_q == WIN_LAST) begin
                  win_cnt_d = '0;
                  err_win_d = '0;
               end else begin
                  win_cnt_d = win_cnt_q + 1'b1;
                  if (mismatch) begin
                     err_win_d = err_win_q + 1'b1;
                  end
               end
            end
            default: state_d = SEED;
         endcase
      end
      if (bus.clr_cnt) begin
         err_cnt_d = '0;
      end
      locked_d = (state_d == LOCKED);
   end

   // All checker state and registered status outputs
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= SEED;
         seed_cnt_q  <= '0;
         good_cnt_q  <= '0;
         win_cnt_q   <= '0;
         err_win_q   <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         seed_cnt_q  <= seed_cnt_d;
         good_cnt_q  <= good_cnt_d;
         win_cnt_q   <= win_cnt_d;
         err_win_q   <= err_win_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_cnt   = err_cnt_q;

`ifdef PRBS31_CHK_BITCNT_EN
   logic [31:0] bit_cnt_q, bit_cnt_d;

   // Count valid bits sampled while locked; clear wins over a simultaneous increment
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      if (bus.din_valid && (state_q == LOCKED) && (bit_cnt_q != 32'hFFFF_FFFF)) begin
         bit_cnt_d = bit_cnt_q + 32'd1;
      end
      if (bus.clr_cnt) begin
         bit_cnt_d = '0;
      end
   end

   // Checked-bit counter register
   always_ff @(posedge clk) begin
      if (rst_n) begin
         bit_cnt_q <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign bus.bit_cnt = bit_cnt_q;
`else
   assign bus.bit_cnt = '0;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// tb/tb_prbs31_checker.sv - directed/randomized bench for prbs31_checker with a queue-based reference model
module tb_prbs31_checker;
   import prbs31_pkg::*;

   localparam int LG = 64;
   localparam int LW = 256;
   localparam int LT = 8;
`ifdef PRBS31_CHK_BITCNT_EN
   localparam bit BITCNT = 1'b1;
`else
   localparam bit BITCNT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic sat_rst;
   always #5 clk = ~clk;

   prbs31_checker_if bus ();
   prbs31_checker_if sat_bus ();

   prbs31_checker #(.LOCK_GOOD(LG), .LOSS_WIN(LW), .LOSS_THR(LT)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Second instance whose threshold exceeds its window, so constant errors never drop lock
   prbs31_checker #(.LOCK_GOOD(LG), .LOSS_WIN(LW), .LOSS_THR(512)) u_sat (
      .clk   (clk),
      .rst_n (sat_rst),
      .bus   (sat_bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: history as a bit queue (index 0 oldest), phases 0 seed / 1 confirm / 2 track
   bit          hist[$];
   int          m_phase, m_seed_n, m_good_n, m_win_n, m_win_err;
   logic        e_locked, e_pulse;
   logic [15:0] e_err;
   logic [31:0] e_bits;

   logic [30:0] g, sat_g;
   int          sat_n;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic m_reset();
      hist = {};
      repeat (31) hist.push_back(1'b0);
      m_phase = 0; m_seed_n = 0; m_good_n = 0; m_win_n = 0; m_win_err = 0;
      e_locked = 1'b0; e_pulse = 1'b0; e_err = '0; e_bits = '0;
   endtask

   task automatic m_update(input bit r, input bit d, input bit v, input bit c);
      bit pred, miss, in_bit, was_track, any1;
      if (r) begin
         m_reset();
         return;
      end
      e_pulse = 1'b0;
      if (v) begin
         pred      = hist[0] ^ hist[3];
         miss      = d ^ pred;
         was_track = (m_phase == 2);
         in_bit    = was_track ? pred : d;
         void'(hist.pop_front());
         hist.push_back(in_bit);
         if (m_phase == 0) begin
            m_seed_n++;
            if (m_seed_n == 31) begin
               m_seed_n = 0;
               any1 = 1'b0;
               foreach (hist[i]) any1 |= hist[i];
               if (any1) begin m_phase = 1; m_good_n = 0; end
            end
         end else if (m_phase == 1) begin
            if (miss) begin
               m_phase = 0; m_seed_n = 0;
            end else begin
               m_good_n++;
               if (m_good_n == LG) begin m_phase = 2; m_win_n = 0; m_win_err = 0; end
            end
         end else begin
            if (miss) begin
               e_pulse = 1'b1;
               if (e_err != 16'hFFFF) e_err++;
               m_win_err++;
            end
            m_win_n++;
            if (m_win_err == LT) begin
               m_phase = 0; m_seed_n = 0; m_win_n = 0; m_win_err = 0;
            end else if (m_win_n == LW) begin
               m_win_n = 0; m_win_err = 0;
            end
         end
         if (was_track && BITCNT && e_bits != 32'hFFFF_FFFF) e_bits++;
      end
      if (c) begin e_err = '0; e_bits = '0; end
      e_locked = (m_phase == 2);
   endtask

   task automatic main_gen(output bit b);
      b = g[27] ^ g[30];
      g = {g[29:0], b};
   endtask

   // One clock: drive both instances, advance the model, compare the main instance
   task automatic step(input bit r, input bit d, input bit v, input bit c);
      bit sb;
      rst_n = r; bus.din = d; bus.din_valid = v; bus.clr_cnt = c;
      if (sat_rst) begin
         sat_bus.din = 1'b0; sat_bus.din_valid = 1'b0;
      end else begin
         sb = sat_g[27] ^ sat_g[30];
         sat_g = {sat_g[29:0], sb};
         sat_bus.din = sb ^ (sat_n >= 95);
         sat_bus.din_valid = 1'b1;
         sat_n++;
      end
      sat_bus.clr_cnt = 1'b0;
      @(posedge clk);
      #1;
      m_update(r, d, v, c);
      check("locked", bus.locked, e_locked);
      check("err_pulse", bus.err_pulse, e_pulse);
      check("err_cnt", bus.err_cnt, e_err);
      check("bit_cnt", bus.bit_cnt, e_bits);
   endtask

   initial begin
      bit b, lmin, lmax;
      int lock_at, vb, pulses, relock, guard;
      g = 31'd1; sat_g = 31'd1; sat_n = 0; sat_rst = 1'b1;
      m_reset();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("rst_locked", bus.locked, 1'b0);
      check("rst_err_cnt", bus.err_cnt, 16'h0);
      sat_rst = 1'b0;

      // Clean seeded stream: lock after exactly 95 bits, no errors over 10000 bits
      lock_at = -1; vb = 0;
      for (int i = 0; i < 10000; i++) begin
         main_gen(b); step(0, b, 1, 0); vb++;
         if (lock_at < 0 && bus.locked) lock_at = vb;
      end
      check("lock_point", lock_at, 95);
      check("clean_err_cnt", bus.err_cnt, 16'h0);

      // Single corrupted bit gives one error and lock holds
      pulses = 0; lmin = 1'b1;
      main_gen(b); step(0, ~b, 1, 0);
      pulses += bus.err_pulse; lmin &= bus.locked;
      for (int i = 0; i < 300; i++) begin
         main_gen(b); step(0, b, 1, 0);
         pulses += bus.err_pulse; lmin &= bus.locked;
      end
      check("single_pulses", pulses, 1);
      check("single_err_cnt", bus.err_cnt, 16'd1);
      check("single_locked_held", lmin, 1'b1);

      // Clear, align to a window start, then 8 errors within 71 bits
      main_gen(b); step(0, b, 1, 1);
      check("clr_err_cnt", bus.err_cnt, 16'h0);
      guard = 0;
      while (m_win_n != 0 && guard < 300) begin
         main_gen(b); step(0, b, 1, 0); guard++;
      end
      for (int k = 0; k <= 70; k++) begin
         main_gen(b); step(0, b ^ bit'(k % 10 == 0), 1, 0);
      end
      check("loss_locked", bus.locked, 1'b0);
      relock = -1;
      for (int k = 1; k <= 200; k++) begin
         main_gen(b); step(0, b, 1, 0);
         if (relock < 0 && bus.locked) relock = k;
      end
      check("relock_point", relock, 95);
      check("loss_err_cnt", bus.err_cnt, 16'd8);

      // Clear coincident with an error: pulse still fires, count ends at zero
      main_gen(b); step(0, ~b, 1, 1);
      check("clr_hit_pulse", bus.err_pulse, 1'b1);
      check("clr_hit_err_cnt", bus.err_cnt, 16'h0);

      // Reset mid-window with a nonzero count
      main_gen(b); step(0, ~b, 1, 0);
      for (int i = 0; i < 10; i++) begin main_gen(b); step(0, b, 1, 0); end
      step(1, 1, 1, 0);
      check("midrst_locked", bus.locked, 1'b0);
      check("midrst_err_pulse", bus.err_pulse, 1'b0);
      check("midrst_err_cnt", bus.err_cnt, 16'h0);
      check("midrst_bit_cnt", bus.bit_cnt, 32'h0);

      // Random valid gaps on a fresh clean stream: same lock point in valid bits
      g = 31'd1; lock_at = -1; vb = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 70) begin
            main_gen(b); step(0, b, 1, 0); vb++;
         end else begin
            step(0, bit'($urandom), 0, 0);
         end
         if (lock_at < 0 && bus.locked) lock_at = vb;
      end
      check("gap_lock_point", lock_at, 95);
      check("gap_err_cnt", bus.err_cnt, 16'h0);

      // Constant zero input never locks
      step(1, 0, 0, 0);
      lmax = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         step(0, 0, 1, 0); lmax |= bus.locked;
      end
      check("zero_never_locked", lmax, 1'b0);
      check("zero_err_cnt", bus.err_cnt, 16'h0);

      // Saturating error count on the second instance
      for (int i = 0; i < 70000 && sat_n < 95 + 65534; i++) step(0, 0, 0, 0);
      check("sat_below", sat_bus.err_cnt, 16'hFFFE);
      step(0, 0, 0, 0);
      check("sat_reach", sat_bus.err_cnt, 16'hFFFF);
      repeat (20) step(0, 0, 0, 0);
      check("sat_hold", sat_bus.err_cnt, 16'hFFFF);
      check("sat_pulse", sat_bus.err_pulse, 1'b1);
      check("sat_locked", sat_bus.locked, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prbs31_checker.md
PRBS31_CHECKER -- requirements
Module: prbs31_checker

Interface
REQ-001 SHALL have parameter LOCK_GOOD, default 64: consecutive correct predictions needed to declare lock.
REQ-002 SHALL have parameter LOSS_WIN, default 256: valid bits per loss-of-lock window.
REQ-003 SHALL have parameter LOSS_THR, default 8: errors within one window that force loss of lock.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-high reset (1 = reset, despite the name).
REQ-006 SHALL have port din  input  1  serial PRBS31 bit under test.
REQ-007 SHALL have port din_valid  input  1  din sampled only when 1.
REQ-008 SHALL have port clr_cnt  input  1  synchronous clear of err_cnt.
REQ-009 SHALL have port locked  output  1  checker synchronised to the stream.
REQ-010 SHALL have port err_pulse  output  1  one-cycle flag per mismatched bit while locked.
REQ-011 SHALL have port err_cnt  output  16  saturating error count.
REQ-012 SHALL have port bit_cnt  output  32  saturating count of valid bits checked while locked.

Function
REQ-013 SHALL keep 31-bit history sr, sr[0] newest, sr[30] oldest; prediction exp = sr[27] ^ sr[30] (x^31+x^28+1, same bit order as the project's PRBS31 generator output).
REQ-014 SHALL implement FSM SEED -> VERIFY -> LOCKED; only valid cycles advance counters or state.
REQ-015 SEED: shift din into sr; after 31 valid bits go to VERIFY if sr != 0, otherwise restart the 31-bit count.
REQ-016 VERIFY: compare din to exp and shift din into sr; LOCK_GOOD consecutive matches -> LOCKED; any mismatch -> SEED with count reset.
REQ-017 LOCKED: shift exp (not din) into sr, so one corrupted bit yields exactly one error.
REQ-018 LOCKED: mismatch asserts err_pulse for exactly the cycle after the sampling edge; err_pulse is 0 in SEED and VERIFY.
REQ-019 locked SHALL be registered: it rises the cycle after the LOCK_GOOD-th match and falls the cycle after the loss decision.
REQ-020 LOCKED: window counter counts valid bits; LOSS_THR errors before LOSS_WIN bits elapse -> SEED; at window end, reset the window counters.
REQ-021 err_cnt SHALL increment on each LOCKED mismatch, hold at 16'hFFFF, and persist across loss and relock.
REQ-022 clr_cnt SHALL zero err_cnt and bit_cnt next cycle and take priority over a simultaneous increment; err_pulse still asserts.
REQ-023 din_valid = 0 SHALL freeze sr, FSM, and all counters; err_pulse = 0.

Reset
REQ-024 rst_n = 1 at a clock edge SHALL set sr = 0, state = SEED, and all counters = 0, and drive locked = 0, err_pulse = 0, err_cnt = 0, bit_cnt = 0, from any state, including mid-window.

Configuration
REQ-025 With PRBS31_CHK_BITCNT_EN defined, bit_cnt SHALL count valid LOCKED bits, saturating at 32'hFFFFFFFF, cleared by clr_cnt.
REQ-026 Without PRBS31_CHK_BITCNT_EN, bit_cnt SHALL be a constant 0 and no counter flops are synthesised.

Structure
REQ-027 Package prbs31_pkg SHALL hold tap constants (30, 27), the state enum {SEED, VERIFY, LOCKED}, and the parameter defaults.
REQ-028 Sub-module prbs31_pred SHALL contain sr and exp, with a select input choosing din or exp as the shift-in bit.

Verification
REQ-029 Reset, then generator-seeded (seed 1) stream with continuous valid: locked = 1 the cycle after the 95th bit; err_cnt = 0 after 10000 bits.
REQ-030 After lock, flip one bit: single err_pulse, err_cnt = 1, locked stays 1, and no further errors.
REQ-031 After lock, flip 8 bits within 256: locked falls; clean stream relocks after 95 more valid bits; err_cnt = 8.
REQ-032 din = 0 constant for 1000 valid bits: locked never asserts; err_cnt = 0.
REQ-033 Random din_valid gaps on a clean stream: identical lock point in valid-bit terms, no errors; clr_cnt coincident with an error gives err_cnt = 0 and err_pulse = 1.
REQ-034 Force err_cnt to 16'hFFFF via errors, add one more error: err_cnt stays 16'hFFFF; assert rst_n mid-window: all outputs 0 next cycle.
